ext_irq_ctrl: RTL

- External interrupt controller that drives the processor's ExtIRQ/ExtIAck handshake; the requesting end of the exception interface that the core's controller answers.
- Collects rising edges from N_SRC device lines, holds them as pending, and masks them.
- Selects the highest-priority source (lowest index), raises ExtIRQ and holds it until ExtIAck, then blocks new requests until the handler returns (ERet).

---
 rtl/ext_irq_ctrl_pkg.sv | 14 +
 rtl/ext_irq_ctrl_prio_enc.sv | 23 ++
 rtl/ext_irq_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ext_irq_ctrl_pkg.sv
// Shared types and constants for the external interrupt controller.
// Optional build macro used by the top: IRQ_OVF_CNT_EN.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam int         IRQ_N_SRC_DEF = 4;
  localparam logic [7:0] OVF_MAX       = 8'hFF;

endpackage

// File: rtl/ext_irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder for the interrupt arbiter.
// Purely combinational; id is 0 when nothing is requested.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N_SRC = IRQ_N_SRC_DEF,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             any
);

  // scan from the top down so the lowest set index is written last
  always_comb begin
    id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: edge capture, masking, ExtIRQ/ExtIAck/ERet handshake.
// Build macro IRQ_OVF_CNT_EN enables the saturating dropped-edge counter.
module ext_irq_ctrl
  import irq_pkg::*;
#(
  parameter  int N_SRC = IRQ_N_SRC_DEF,
  localparam int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             ExtIAck,
  input  logic             ERet,
  output logic             ExtIRQ,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] irq_pending,
  output logic             busy,
  output logic [7:0]       ovf_count
);

  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  irq_state_t       state;
  irq_state_t       state_nxt;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] pend_nxt;
  logic             irq_nxt;
  logic [ID_W-1:0]  id_nxt;
  logic [ID_W-1:0]  enc_id;
  logic             enc_any;
  logic             ack_take;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_enc (
    .req (irq_pending & irq_mask),
    .id  (enc_id),
    .any (enc_any)
  );

  // edge detect and pending update; a same-cycle edge beats the ack clear
  always_comb begin
    edges    = irq_in & ~prev;
    ack_take = (state == REQ) && ExtIAck;
    clr      = ack_take ? (ONE << irq_id) : '0;
    pend_nxt = (irq_pending & ~clr) | edges;
  end

  // next-state and registered-output decode
  always_comb begin
    state_nxt = state;
    irq_nxt   = ExtIRQ;
    id_nxt    = irq_id;
    unique case (state)
      IDLE: begin
        if (enc_any) begin
          state_nxt = REQ;
          irq_nxt   = 1'b1;
          id_nxt    = enc_id;
        end
      end
      REQ: begin
        if (ExtIAck) begin
          state_nxt = SERVICE;
          irq_nxt   = 1'b0;
        end
      end
      SERVICE: begin
        if (ERet) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        irq_nxt   = 1'b0;
      end
    endcase
  end

  // state, edge history, pending and request registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      prev        <= '0;
      irq_pending <= '0;
      ExtIRQ      <= 1'b0;
      irq_id      <= '0;
    end else begin
      state       <= state_nxt;
      prev        <= irq_in;
      irq_pending <= pend_nxt;
      ExtIRQ      <= irq_nxt;
      irq_id      <= id_nxt;
    end
  end

  assign busy = (state != IDLE);

`ifdef IRQ_OVF_CNT_EN
  logic [N_SRC-1:0] drop;
  logic [4:0]       drop_cnt;
  logic [8:0]       ovf_sum;
  logic [7:0]       ovf_q;

  // count edges merged into an already-pending, uncleared bit
  always_comb begin
    drop     = edges & irq_pending & ~clr;
    drop_cnt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      drop_cnt = drop_cnt + 5'(drop[i]);
    end
    ovf_sum = {1'b0, ovf_q} + 9'(drop_cnt);
  end

  // saturating dropped-edge counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= '0;
    end else if (ovf_sum > {1'b0, OVF_MAX}) begin
      ovf_q <= OVF_MAX;
    end else begin
      ovf_q <= ovf_sum[7:0];
    end
  end

  assign ovf_count = ovf_q;
`else
  assign ovf_count = 8'h00;
`endif

endmodule
